// File: rtl/uart_rx_if.sv
// Signal bundle between a UART receiver and its user: line/tick/format inputs
// toward the receiver, received word and status flags back.
interface uart_rx_if #(
  parameter int MAX_DATA_BIT_NUM = 8
);
  logic                        enable_i;
  logic                        rx_i;
  logic                        baud_tick_i;
  logic                        data_bit_num_i;
  logic                        stop_bit_num_i;
  logic [MAX_DATA_BIT_NUM-1:0] data_o;
  logic                        data_valid_o;
  logic                        frame_err_o;
  logic                        busy_o;
  logic                        start_complete_o;
  logic                        data_complete_o;
  logic                        rx_complete_o;

  modport master (
    output enable_i, rx_i, baud_tick_i, data_bit_num_i, stop_bit_num_i,
    input  data_o, data_valid_o, frame_err_o, busy_o,
           start_complete_o, data_complete_o, rx_complete_o
  );

  modport slave (
    input  enable_i, rx_i, baud_tick_i, data_bit_num_i, stop_bit_num_i,
    output data_o, data_valid_o, frame_err_o, busy_o,
           start_complete_o, data_complete_o, rx_complete_o
  );
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver, 7/8 data bits, 1/2 stop bits, LSB first.
// Define UART_RX_SYNC_EN to put a two-flop synchronizer on rx_i.
module uart_rx #(
  parameter int MAX_DATA_BIT_NUM = 8,
  parameter int OVERSAMPLE       = 16
) (
  input logic     clk_i,
  input logic     s_rst_n_i,
  uart_rx_if.slave bus
);

  localparam int CW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
  localparam int W  = MAX_DATA_BIT_NUM;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RECV  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t         state_reg;
  logic [CW-1:0]  tick_cnt_reg;
  logic [3:0]     bit_cnt_reg;
  logic [W-1:0]   shift_reg;
  logic           seven_reg;
  logic           two_stop_reg;
  logic           stop_idx_reg;
  logic           stop_err_reg;
  logic           rx_prev_reg;
  logic [W-1:0]   data_reg;
  logic           data_valid_reg;
  logic           frame_err_reg;
  logic           busy_reg;
  logic           start_done_reg;
  logic           data_done_reg;
  logic           rx_done_reg;
  logic           rx_s;

`ifdef UART_RX_SYNC_EN
  logic [1:0] sync_reg;

  always_ff @(posedge clk_i) begin
    if (!s_rst_n_i) begin
      sync_reg <= 2'b11;
    end else begin
      sync_reg <= {sync_reg[0], bus.rx_i};
    end
  end

  assign rx_s = sync_reg[1];
`else
  assign rx_s = bus.rx_i;
`endif

  // Bits shift in from the top, so a short word must be moved down by the unused width.
  logic [W-1:0] word_shifted;
  logic [W-1:0] word_aligned;

  assign word_shifted = seven_reg ? (shift_reg >> (W - 7)) : (shift_reg >> (W - 8));

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_mask
      assign word_aligned[gi] = word_shifted[gi] & ((gi < 7) || ((gi == 7) && !seven_reg));
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (!s_rst_n_i) begin
      state_reg      <= IDLE;
      tick_cnt_reg   <= '0;
      bit_cnt_reg    <= '0;
      shift_reg      <= '0;
      seven_reg      <= 1'b0;
      two_stop_reg   <= 1'b0;
      stop_idx_reg   <= 1'b0;
      stop_err_reg   <= 1'b0;
      rx_prev_reg    <= 1'b1;
      data_reg       <= '0;
      data_valid_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      busy_reg       <= 1'b0;
      start_done_reg <= 1'b0;
      data_done_reg  <= 1'b0;
      rx_done_reg    <= 1'b0;
    end else begin
      data_valid_reg <= 1'b0;
      if (bus.baud_tick_i) begin
        rx_prev_reg <= rx_s;
        case (state_reg)
          IDLE: begin
            if (bus.enable_i && rx_prev_reg && !rx_s) begin
              state_reg      <= START;
              busy_reg       <= 1'b1;
              tick_cnt_reg   <= '0;
              start_done_reg <= 1'b0;
              data_done_reg  <= 1'b0;
              rx_done_reg    <= 1'b0;
            end
          end
          START: begin
            if (tick_cnt_reg == CW'(OVERSAMPLE / 2 - 1)) begin
              tick_cnt_reg <= '0;
              if (!rx_s) begin
                state_reg      <= RECV;
                start_done_reg <= 1'b1;
                seven_reg      <= bus.data_bit_num_i;
                two_stop_reg   <= bus.stop_bit_num_i;
                bit_cnt_reg    <= '0;
                shift_reg      <= '0;
              end else begin
                state_reg <= IDLE;
                busy_reg  <= 1'b0;
              end
            end else begin
              tick_cnt_reg <= tick_cnt_reg + 1'b1;
            end
          end
          RECV: begin
            if (tick_cnt_reg == CW'(OVERSAMPLE - 1)) begin
              tick_cnt_reg <= '0;
              shift_reg    <= {rx_s, shift_reg[W-1:1]};
              bit_cnt_reg  <= bit_cnt_reg + 4'd1;
              if (bit_cnt_reg == (seven_reg ? 4'd6 : 4'd7)) begin
                state_reg     <= STOP;
                data_done_reg <= 1'b1;
                stop_idx_reg  <= 1'b0;
                stop_err_reg  <= 1'b0;
              end
            end else begin
              tick_cnt_reg <= tick_cnt_reg + 1'b1;
            end
          end
          STOP: begin
            if (tick_cnt_reg == CW'(OVERSAMPLE - 1)) begin
              tick_cnt_reg <= '0;
              if (two_stop_reg && !stop_idx_reg) begin
                stop_idx_reg <= 1'b1;
                stop_err_reg <= !rx_s;
              end else begin
                state_reg      <= IDLE;
                busy_reg       <= 1'b0;
                data_reg       <= word_aligned;
                data_valid_reg <= 1'b1;
                frame_err_reg  <= stop_err_reg | !rx_s;
                rx_done_reg    <= 1'b1;
                // Keep the pre-sample line level so a start edge landing on this tick is still seen.
                rx_prev_reg    <= rx_prev_reg;
              end
            end else begin
              tick_cnt_reg <= tick_cnt_reg + 1'b1;
            end
          end
          default: begin
            state_reg    <= IDLE;
            busy_reg     <= 1'b0;
            tick_cnt_reg <= '0;
          end
        endcase
      end
    end
  end

  assign bus.data_o           = data_reg;
  assign bus.data_valid_o     = data_valid_reg;
  assign bus.frame_err_o      = frame_err_reg;
  assign bus.busy_o           = busy_reg;
  assign bus.start_complete_o = start_done_reg;
  assign bus.data_complete_o  = data_done_reg;
  assign bus.rx_complete_o    = rx_done_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table of frames plus hand sequences for
// false start, back-to-back frames, enable gating and mid-frame reset.
module tb_uart_rx;

  localparam int OS = 16;

  logic clk_i;
  logic s_rst_n_i;

  uart_rx_if #(.MAX_DATA_BIT_NUM(8)) bus ();

  uart_rx #(.MAX_DATA_BIT_NUM(8), .OVERSAMPLE(OS)) dut (
    .clk_i    (clk_i),
    .s_rst_n_i(s_rst_n_i),
    .bus      (bus)
  );

  typedef struct {
    logic [7:0] data;
    logic       seven;
    logic       two;
    logic       s0;
    logic       s1;
    logic [7:0] exp_data;
    logic       exp_err;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic       e;
  } exp_t;

  exp_t       sb[$];
  int         checks;
  int         errors;
  int         pulses;
  int         tick_gap;
  int         tick_div;
  logic [7:0] last_exp_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    bus.baud_tick_i = 1'b0;
    tick_div = 0;
    forever begin
      @(negedge clk_i);
      if (tick_div >= tick_gap - 1) begin
        bus.baud_tick_i = 1'b1;
        tick_div = 0;
      end else begin
        bus.baud_tick_i = 1'b0;
        tick_div++;
      end
    end
  end

  // Scoreboard consumer: every valid pulse must match the oldest queued frame.
  initial begin
    forever begin
      @(negedge clk_i);
      if (bus.data_valid_o === 1'b1) begin
        exp_t e;
        pulses++;
        if (sb.size() == 0) begin
          chk("unexpected_valid", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("data_o", 32'(bus.data_o), 32'(e.d));
          chk("frame_err_o", 32'(bus.frame_err_o), 32'(e.e));
          last_exp_data = e.d;
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic next_tick();
    do @(posedge clk_i); while (bus.baud_tick_i !== 1'b1);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bus.rx_i = b;
    repeat (OS) next_tick();
  endtask

  task automatic send_frame(input logic [7:0] d, input logic seven, input logic two,
                            input logic s0, input logic s1, input logic drop_en);
    int p0;
    p0 = pulses;
    bus.data_bit_num_i = seven;
    bus.stop_bit_num_i = two;
    send_bit(1'b0);
    if (drop_en) bus.enable_i = 1'b0;
    for (int i = 0; i < (seven ? 7 : 8); i++) send_bit(d[i]);
    chk("data_hold", 32'(bus.data_o), 32'(last_exp_data));
    send_bit(s0);
    if (two) begin
      chk("no_pulse_before_stop2", 32'(pulses - p0), 32'd0);
      send_bit(s1);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_data"}, 32'(bus.data_o), 32'd0);
    chk({tag, "_valid"}, 32'(bus.data_valid_o), 32'd0);
    chk({tag, "_ferr"}, 32'(bus.frame_err_o), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy_o), 32'd0);
    chk({tag, "_flags"}, 32'({bus.start_complete_o, bus.data_complete_o, bus.rx_complete_o}), 32'd0);
  endtask

  initial begin
    vec_t vecs[7];
    int   p0;

    vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0};
    vecs[1] = '{8'h7F, 1'b1, 1'b1, 1'b1, 1'b1, 8'h7F, 1'b0};
    vecs[2] = '{8'hD5, 1'b1, 1'b0, 1'b1, 1'b1, 8'h55, 1'b0};
    vecs[3] = '{8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0};
    vecs[4] = '{8'h81, 1'b0, 1'b1, 1'b1, 1'b0, 8'h81, 1'b1};
    vecs[5] = '{8'hC6, 1'b1, 1'b1, 1'b0, 1'b1, 8'h46, 1'b1};
    vecs[6] = '{8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 1'b1};

    checks = 0;
    errors = 0;
    pulses = 0;
    tick_gap = 4;
    last_exp_data = 8'h00;
    s_rst_n_i = 1'b0;
    bus.enable_i = 1'b1;
    bus.rx_i = 1'b1;
    bus.data_bit_num_i = 1'b0;
    bus.stop_bit_num_i = 1'b0;

    repeat (5) @(posedge clk_i);
    #1;
    check_outputs_zero("reset");
    s_rst_n_i = 1'b1;
    repeat (4) next_tick();

    for (int i = 0; i < 7; i++) begin
      tick_gap = (i % 2 == 0) ? 4 : 9;
      p0 = pulses;
      sb.push_back('{vecs[i].exp_data, vecs[i].exp_err});
      send_frame(vecs[i].data, vecs[i].seven, vecs[i].two, vecs[i].s0, vecs[i].s1, 1'b0);
      send_bit(1'b1);
      chk($sformatf("vec%0d_pulses", i), 32'(pulses - p0), 32'd1);
      chk($sformatf("vec%0d_flags", i),
          32'({bus.start_complete_o, bus.data_complete_o, bus.rx_complete_o}), 32'd7);
      chk($sformatf("vec%0d_busy", i), 32'(bus.busy_o), 32'd0);
    end
    tick_gap = 4;

    // False start: low for 4 ticks only.
    p0 = pulses;
    bus.rx_i = 1'b0;
    repeat (4) next_tick();
    chk("false_start_busy_mid", 32'(bus.busy_o), 32'd1);
    bus.rx_i = 1'b1;
    repeat (40) next_tick();
    chk("false_start_pulses", 32'(pulses - p0), 32'd0);
    chk("false_start_busy", 32'(bus.busy_o), 32'd0);
    chk("false_start_flag", 32'(bus.start_complete_o), 32'd0);
    chk("false_start_ferr_hold", 32'(bus.frame_err_o), 32'd1);
    chk("false_start_data_hold", 32'(bus.data_o), 32'(last_exp_data));

    // Back-to-back frames with no idle gap.
    p0 = pulses;
    sb.push_back('{8'h01, 1'b0});
    sb.push_back('{8'hFE, 1'b0});
    send_frame(8'h01, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    send_frame(8'hFE, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    send_bit(1'b1);
    chk("b2b_pulses", 32'(pulses - p0), 32'd2);

    // Enable low in idle blocks the frame.
    p0 = pulses;
    bus.enable_i = 1'b0;
    send_frame(8'h99, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    send_bit(1'b1);
    chk("disabled_pulses", 32'(pulses - p0), 32'd0);
    chk("disabled_busy", 32'(bus.busy_o), 32'd0);
    bus.enable_i = 1'b1;

    // Enable dropped after the start bit does not abort.
    p0 = pulses;
    sb.push_back('{8'h5A, 1'b0});
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    send_bit(1'b1);
    bus.enable_i = 1'b1;
    chk("drop_en_pulses", 32'(pulses - p0), 32'd1);

    // One-cycle reset during data bit 3 of 0x0F, then a clean 0x55.
    p0 = pulses;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    bus.rx_i = 1'b1;
    repeat (4) next_tick();
    chk("pre_reset_busy", 32'(bus.busy_o), 32'd1);
    @(negedge clk_i);
    s_rst_n_i = 1'b0;
    @(negedge clk_i);
    s_rst_n_i = 1'b1;
    check_outputs_zero("midreset");
    last_exp_data = 8'h00;
    repeat (2 * OS) next_tick();
    chk("midreset_pulses", 32'(pulses - p0), 32'd0);
    sb.push_back('{8'h55, 1'b0});
    send_frame(8'h55, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    send_bit(1'b1);
    chk("after_reset_pulses", 32'(pulses - p0), 32'd1);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
